// File: rtl/dma_engine.sv
// -----------------------------------------------------------------------------
// dma_engine
//   Burst DMA initiator for the banked scratchpad's DMA port. It accepts one
//   command at a time and moves cmd_len words between a streaming interface and
//   memory. The write direction takes words from in_*. The read direction
//   delivers words on out_* through a 2-entry output FIFO.
//
// Ports
//   clk, rst_n              clock (rising edge), synchronous active-low reset
//   cmd_valid/cmd_ready     command handshake; ready only while idle
//   cmd_dir                 0 = stream->memory, 1 = memory->stream
//   cmd_addr                global start word address {bank, local}
//   cmd_len                 word count, 0 allowed
//   in_valid/in_ready/in_data     write-direction stream
//   out_valid/out_ready/out_data  read-direction stream
//   busy, done              burst in progress / one-cycle completion pulse
//   dma_write_en, dma_read_en, dma_bank_sel, dma_local_addr, dma_data_in
//                           scratchpad DMA port strobes, address and write data
//   dma_rdata               read data, valid one cycle after dma_read_en
// -----------------------------------------------------------------------------
module dma_engine #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int NB        = 4,
    parameter int BANK_BITS = $clog2(NB),
    parameter int LEN_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_dir,
    input  logic [BANK_BITS+ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]            cmd_len,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        busy,
    output logic                        done,
    output logic                        dma_write_en,
    output logic                        dma_read_en,
    output logic [BANK_BITS-1:0]        dma_bank_sel,
    output logic [ADDR_W-1:0]           dma_local_addr,
    output logic [DATA_W-1:0]           dma_data_in,
    input  logic [DATA_W-1:0]           dma_rdata
);

    localparam int GA_W = BANK_BITS + ADDR_W;
    localparam logic [GA_W-1:0]  ADDR_ONE = GA_W'(1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [GA_W-1:0]   r_cur_addr;
    // Words still to write (WRITE) or still to issue as reads (READ).
    logic [LEN_W-1:0]  r_issue_left;
    // Words still to hand to the read-stream sink.
    logic [LEN_W-1:0]  r_deliver_left;
    // A read was issued last cycle; its data is on dma_rdata this cycle.
    logic              r_inflight;
    logic [DATA_W-1:0] r_fifo [0:1];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_fifo_cnt;

    logic              w_wr_fire;
    logic              w_rd_fire;
    logic              w_pop;
    logic [1:0]        w_occ;

    assign w_pop     = (r_fifo_cnt != 2'd0) && out_ready;
    assign w_wr_fire = (r_state == S_WRITE) && (r_issue_left != '0) && in_valid;

    // Occupancy counts FIFO entries plus the read still in flight, so a slot is
    // reserved for every outstanding read. A pop this cycle frees its slot now,
    // which is what sustains one word per cycle with out_ready held high.
    assign w_occ     = r_fifo_cnt + {1'b0, r_inflight};
    assign w_rd_fire = (r_state == S_READ) && (r_issue_left != '0) &&
                       ((w_occ - {1'b0, w_pop}) < 2'd2);

    assign cmd_ready      = (r_state == S_IDLE);
    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_DONE);
    assign in_ready       = (r_state == S_WRITE) && (r_issue_left != '0);
    assign dma_write_en   = w_wr_fire;
    assign dma_read_en    = w_rd_fire;
    assign dma_bank_sel   = r_cur_addr[GA_W-1 -: BANK_BITS];
    assign dma_local_addr = r_cur_addr[ADDR_W-1:0];
    assign dma_data_in    = in_data;
    assign out_valid      = (r_fifo_cnt != 2'd0);
    assign out_data       = r_fifo[r_rd_ptr];

    // Control path: FSM, address/length counters and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cur_addr     <= '0;
            r_issue_left   <= '0;
            r_deliver_left <= '0;
            r_inflight     <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_wr_ptr       <= 1'b0;
            r_fifo_cnt     <= 2'd0;
        end else begin
            r_inflight <= w_rd_fire;
            if (r_inflight) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)      r_rd_ptr <= ~r_rd_ptr;
            r_fifo_cnt <= r_fifo_cnt + {1'b0, r_inflight} - {1'b0, w_pop};

            // Address wraps naturally at 2^GA_W; local overflow carries into bank.
            if (w_wr_fire || w_rd_fire) begin
                r_cur_addr   <= r_cur_addr + ADDR_ONE;
                r_issue_left <= r_issue_left - LEN_ONE;
            end
            if (w_pop) r_deliver_left <= r_deliver_left - LEN_ONE;

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_cur_addr     <= cmd_addr;
                        r_issue_left   <= cmd_len;
                        r_deliver_left <= cmd_len;
                        if (cmd_len == '0)
                            r_state <= S_DONE;
                        else if (cmd_dir)
                            r_state <= S_READ;
                        else
                            r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (w_wr_fire && (r_issue_left == LEN_ONE)) r_state <= S_DONE;
                end
                S_READ: begin
                    if (w_pop && (r_deliver_left == LEN_ONE)) r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Data path: FIFO storage, captured the cycle after each read is issued.
    always_ff @(posedge clk) begin
        if (r_inflight) r_fifo[r_wr_ptr] <= dma_rdata;
    end

endmodule
